// File: rtl/tow_referee.sv
// Tug-of-War round referee: arms a round, awards it to the first fresh
// button press, moves the rope, enforces a cooldown and latches a winner.
module tow_referee #(
    parameter int POS_W    = 3,
    parameter int POS_MAX  = 6,
    parameter int COOL_CYC = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             pb_l,
    input  logic             pb_r,
    output logic [POS_W-1:0] pos,
    output logic             point_l,
    output logic             point_r,
    output logic             armed,
    output logic             win_l,
    output logic             win_r
);

    localparam logic [POS_W-1:0] CENTER  = POS_W'(POS_MAX / 2);
    localparam logic [POS_W-1:0] MAX_POS = POS_W'(POS_MAX);
    localparam int               CNT_W   = (COOL_CYC > 1) ? $clog2(COOL_CYC) : 1;
    localparam logic [CNT_W-1:0] COOL_LOAD = CNT_W'(COOL_CYC - 1);

    typedef enum logic [1:0] {IDLE, ARMED, COOL, WIN} state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic             hist_l;
    logic             hist_r;
    logic             edge_l;
    logic             edge_r;
    logic [POS_W-1:0] next_pos;

    // A press counts only on the sample where the button goes from low to high.
    assign edge_l = pb_l & ~hist_l;
    assign edge_r = pb_r & ~hist_r;

    // Rope position after this round's presses, clamped to the playing field.
    always_comb begin
        next_pos = pos;
        if (edge_l && !edge_r) begin
            next_pos = (pos == '0) ? pos : pos - POS_W'(1);
        end else if (edge_r && !edge_l) begin
            next_pos = (pos == MAX_POS) ? pos : pos + POS_W'(1);
        end
    end

    // Round sequencer: start has priority, then per-state round handling.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= IDLE;
            pos     <= CENTER;
            point_l <= 1'b0;
            point_r <= 1'b0;
            armed   <= 1'b0;
            win_l   <= 1'b0;
            win_r   <= 1'b0;
            cnt     <= '0;
            hist_l  <= 1'b0;
            hist_r  <= 1'b0;
        end else begin
            hist_l  <= pb_l;
            hist_r  <= pb_r;
            point_l <= 1'b0;
            point_r <= 1'b0;
            if (start) begin
                state <= ARMED;
                pos   <= CENTER;
                armed <= 1'b1;
                win_l <= 1'b0;
                win_r <= 1'b0;
                cnt   <= '0;
            end else begin
                case (state)
                    IDLE: begin
                        state <= IDLE;
                    end
                    ARMED: begin
                        if (edge_l || edge_r) begin
                            pos     <= next_pos;
                            point_l <= edge_l & ~edge_r;
                            point_r <= edge_r & ~edge_l;
                            armed   <= 1'b0;
                            cnt     <= COOL_LOAD;
                            if (next_pos == '0) begin
                                state <= WIN;
                                win_l <= 1'b1;
                            end else if (next_pos == MAX_POS) begin
                                state <= WIN;
                                win_r <= 1'b1;
                            end else begin
                                state <= COOL;
                            end
                        end
                    end
                    COOL: begin
                        if (cnt == '0) begin
                            state <= ARMED;
                            armed <= 1'b1;
                        end else begin
                            cnt <= cnt - CNT_W'(1);
                        end
                    end
                    WIN: begin
                        state <= WIN;
                    end
                    default: begin
                        state <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule
